bec_la_operand_bank: RTL and testbench

Parametrised operand bank and command sequencer between the Caravel logic-analyzer (LA) port and a binary-field elliptic-curve processing core. It loads NUM_OPS operands of OP_WIDTH bits in CHUNK-bit slices from the management SoC and starts the core. It captures the core's results back into the same registers and returns any register slice on request. Commands are sequence-tagged, so each issued command executes exactly once. A watchdog flags a core that never completes.

---
 rtl/bec_la_operand_bank.sv | 258 +++++++++++++++++++++++++
 tb/tb_bec_la_operand_bank.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bec_la_operand_bank.sv
`timescale 1ns/1ps
// Operand bank and command sequencer between the Caravel LA port and a
// binary-field EC core: sliced operand load/readback, start/abort, watchdog.
module bec_la_operand_bank #(
   parameter int unsigned OP_WIDTH = 163,
   parameter int unsigned NUM_OPS  = 7,
   parameter int unsigned CHUNK    = 64,
   parameter int unsigned TIMEOUT  = 4096
) (
   input  logic                        wb_clk_i,
   input  logic                        wb_rst_ni,
   input  logic [127:0]                la_data_in,
   input  logic [127:0]                la_oenb,
   output logic [127:0]                la_data_out,
   output logic [NUM_OPS*OP_WIDTH-1:0] core_op_o,
   output logic                        core_start_o,
   output logic                        core_abort_o,
   input  logic [NUM_OPS*OP_WIDTH-1:0] core_res_i,
   input  logic                        core_done_i
);

   localparam int unsigned NCHUNK = (OP_WIDTH + CHUNK - 1) / CHUNK;
   localparam int unsigned PAD_W  = NCHUNK * CHUNK;
   localparam int unsigned IDX_W  = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
   localparam int unsigned CH_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int unsigned CNT_W  = $clog2(TIMEOUT + 2);

   localparam logic [7:0] OP_NOP   = 8'h00;
   localparam logic [7:0] OP_WRITE = 8'h01;
   localparam logic [7:0] OP_START = 8'h02;
   localparam logic [7:0] OP_READ  = 8'h03;
   localparam logic [7:0] OP_CLEAR = 8'h04;
   localparam logic [7:0] OP_ABORT = 8'h05;

   typedef enum logic [3:0] {
      ST_IDLE = 4'h1,
      ST_RUN  = 4'h2,
      ST_DONE = 4'h3,
      ST_TOUT = 4'h4
   } state_t;

   // Command capture stage
   logic [7:0]       op_q, idx_q, chk_q;
   logic             seq_q, en_q;
   logic [CHUNK-1:0] data_q;

   // Architectural state
   state_t              state_q, state_d;
   logic [OP_WIDTH-1:0] regs_q [NUM_OPS];
   logic [OP_WIDTH-1:0] regs_d [NUM_OPS];
   logic                last_seq_q, last_seq_d;
   logic                err_q, err_d;
   logic                tout_q, tout_d;
   logic                start_q, start_d;
   logic                abort_q, abort_d;
   logic [7:0]          eidx_q, eidx_d;
   logic [7:0]          echk_q, echk_d;
   logic                eseq_q, eseq_d;
   logic [63:0]         rd_q, rd_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   // Slice access helpers
   logic                         cmd_acc, bnd_ok;
   logic                         do_write, do_read, do_clear;
   logic [IDX_W-1:0]             idx_sel;
   logic [CH_W-1:0]              chk_sel;
   logic [NCHUNK-1:0][CHUNK-1:0] rd_pad, wr_pad;
   logic [OP_WIDTH-1:0]          wr_val;
   logic [63:0]                  rd_val;

   logic unused_ok;
   assign unused_ok = &{1'b0, la_data_in[102:0], la_oenb[102:0]};

   // Register the LA command word so decode sees a stable value
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         op_q   <= '0;
         idx_q  <= '0;
         chk_q  <= '0;
         seq_q  <= 1'b0;
         en_q   <= 1'b0;
         data_q <= '0;
      end else begin
         op_q   <= la_data_in[127:120];
         idx_q  <= la_data_in[119:112];
         chk_q  <= la_data_in[111:104];
         seq_q  <= la_data_in[103];
         en_q   <= (la_oenb[127:103] == 25'd0);
         data_q <= la_data_in[CHUNK-1:0];
      end
   end

   assign cmd_acc = en_q & (seq_q ^ last_seq_q);
   assign bnd_ok  = (32'(idx_q) < NUM_OPS) && (32'(chk_q) < NCHUNK);
   assign idx_sel = IDX_W'(idx_q);
   assign chk_sel = CH_W'(chk_q);

   // Chunk view of the addressed register for read and read-modify-write
   always_comb begin
      rd_pad         = PAD_W'(regs_q[idx_sel]);
      rd_val         = 64'(rd_pad[chk_sel]);
      wr_pad         = rd_pad;
      wr_pad[chk_sel] = data_q;
      wr_val         = OP_WIDTH'(wr_pad);
   end

   // Next-state, register bank and status update
   always_comb begin
      state_d    = state_q;
      regs_d     = regs_q;
      last_seq_d = last_seq_q;
      err_d      = err_q;
      tout_d     = tout_q;
      start_d    = 1'b0;
      abort_d    = 1'b0;
      eidx_d     = eidx_q;
      echk_d     = echk_q;
      eseq_d     = eseq_q;
      rd_d       = rd_q;
      cnt_d      = cnt_q;
      do_write   = 1'b0;
      do_read    = 1'b0;
      do_clear   = 1'b0;

      if (cmd_acc) begin
         last_seq_d = seq_q;
         eidx_d     = idx_q;
         echk_d     = chk_q;
         eseq_d     = seq_q;
         case (state_q)
            ST_IDLE: begin
               case (op_q)
                  OP_NOP:   ;
                  OP_WRITE: do_write = 1'b1;
                  OP_START: begin
                     state_d = ST_RUN;
                     start_d = 1'b1;
                     cnt_d   = '0;
                  end
                  OP_READ:  do_read  = 1'b1;
                  OP_CLEAR: do_clear = 1'b1;
                  default:  err_d    = 1'b1;
               endcase
            end
            ST_RUN: begin
               case (op_q)
                  OP_NOP:   ;
                  OP_READ:  do_read = 1'b1;
                  OP_ABORT: begin
                     state_d = ST_IDLE;
                     abort_d = 1'b1;
                  end
                  default:  err_d = 1'b1;
               endcase
            end
            ST_DONE: begin
               case (op_q)
                  OP_NOP:   ;
                  OP_WRITE: do_write = 1'b1;
                  OP_START: begin
                     state_d = ST_RUN;
                     start_d = 1'b1;
                     cnt_d   = '0;
                  end
                  OP_READ:  do_read = 1'b1;
                  OP_CLEAR: begin
                     do_clear = 1'b1;
                     state_d  = ST_IDLE;
                  end
                  default:  err_d = 1'b1;
               endcase
            end
            ST_TOUT: begin
               case (op_q)
                  OP_NOP:   ;
                  OP_READ:  do_read = 1'b1;
                  OP_CLEAR: begin
                     do_clear = 1'b1;
                     state_d  = ST_IDLE;
                  end
                  default:  err_d = 1'b1;
               endcase
            end
            default: ;
         endcase
      end

      // Out-of-range slice accesses are dropped and flagged
      if ((do_write || do_read) && !bnd_ok) begin
         err_d = 1'b1;
      end else if (do_write) begin
         regs_d[idx_sel] = wr_val;
         if (state_q == ST_DONE) state_d = ST_IDLE;
      end else if (do_read) begin
         rd_d = rd_val;
      end

      if (do_clear) begin
         for (int k = 0; k < NUM_OPS; k++) regs_d[k] = '0;
         err_d  = 1'b0;
         tout_d = 1'b0;
      end

      // Completion beats the watchdog; an abort command beats both
      if ((state_q == ST_RUN) && (state_d == ST_RUN) && !start_d) begin
         if (core_done_i) begin
            for (int k = 0; k < NUM_OPS; k++) regs_d[k] = core_res_i[k*OP_WIDTH +: OP_WIDTH];
            state_d = ST_DONE;
         end else if ((TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) == TIMEOUT)) begin
            state_d = ST_TOUT;
            tout_d  = 1'b1;
            abort_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // State and bank registers
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q    <= ST_IDLE;
         for (int k = 0; k < NUM_OPS; k++) regs_q[k] <= '0;
         last_seq_q <= 1'b0;
         err_q      <= 1'b0;
         tout_q     <= 1'b0;
         start_q    <= 1'b0;
         abort_q    <= 1'b0;
         eidx_q     <= '0;
         echk_q     <= '0;
         eseq_q     <= 1'b0;
         rd_q       <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         regs_q     <= regs_d;
         last_seq_q <= last_seq_d;
         err_q      <= err_d;
         tout_q     <= tout_d;
         start_q    <= start_d;
         abort_q    <= abort_d;
         eidx_q     <= eidx_d;
         echk_q     <= echk_d;
         eseq_q     <= eseq_d;
         rd_q       <= rd_d;
         cnt_q      <= cnt_d;
      end
   end

   for (genvar g = 0; g < NUM_OPS; g++) begin : g_flat
      assign core_op_o[g*OP_WIDTH +: OP_WIDTH] = regs_q[g];
   end

   assign core_start_o = start_q;
   assign core_abort_o = abort_q;
   assign la_data_out  = {state_q, err_q, tout_q, 2'b00, eidx_q, echk_q, eseq_q, 39'd0, rd_q};

endmodule

// File: tb/tb_bec_la_operand_bank.sv
`timescale 1ns/1ps
// Self-checking bench for bec_la_operand_bank against a transaction-level model.
module tb_bec_la_operand_bank;

   localparam int OPW  = 163;
   localparam int NOPS = 7;
   localparam int NCH  = 3;
   localparam int TMO  = 16;

   localparam logic [7:0] OP_NOP   = 8'h00;
   localparam logic [7:0] OP_WRITE = 8'h01;
   localparam logic [7:0] OP_START = 8'h02;
   localparam logic [7:0] OP_READ  = 8'h03;
   localparam logic [7:0] OP_CLEAR = 8'h04;
   localparam logic [7:0] OP_ABORT = 8'h05;

   localparam logic [3:0] S_IDLE = 4'h1;
   localparam logic [3:0] S_RUN  = 4'h2;
   localparam logic [3:0] S_DONE = 4'h3;
   localparam logic [3:0] S_TOUT = 4'h4;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [127:0]         la_data_in;
   logic [127:0]         la_oenb;
   logic [127:0]         la_data_out;
   logic [NOPS*OPW-1:0]  core_op_o;
   logic                 core_start_o;
   logic                 core_abort_o;
   logic [NOPS*OPW-1:0]  core_res_i;
   logic                 core_done_i;

   always #5 clk = ~clk;

   bec_la_operand_bank #(
      .OP_WIDTH (OPW),
      .NUM_OPS  (NOPS),
      .CHUNK    (64),
      .TIMEOUT  (TMO)
   ) dut (
      .wb_clk_i     (clk),
      .wb_rst_ni    (rst_n),
      .la_data_in   (la_data_in),
      .la_oenb      (la_oenb),
      .la_data_out  (la_data_out),
      .core_op_o    (core_op_o),
      .core_start_o (core_start_o),
      .core_abort_o (core_abort_o),
      .core_res_i   (core_res_i),
      .core_done_i  (core_done_i)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int start_cnt = 0;
   int abort_cnt = 0;

   // Pulse counters (each pulse spans exactly one falling edge)
   always @(negedge clk) begin
      if (core_start_o) start_cnt <= start_cnt + 1;
      if (core_abort_o) abort_cnt <= abort_cnt + 1;
   end

   // Reference model state
   logic [OPW-1:0] m_reg [NOPS];
   logic [3:0]     m_state;
   logic           m_err, m_tout, m_eseq;
   logic [7:0]     m_eidx, m_echk;
   logic [63:0]    m_rd;
   logic           exp_start, exp_abort;
   logic           seq;

   task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] slice_of(input logic [OPW-1:0] r, input int c);
      logic [191:0] w;
      w = 192'(r) >> (c * 64);
      return w[63:0];
   endfunction

   function automatic logic [OPW-1:0] put_slice(input logic [OPW-1:0] r, input int c, input logic [63:0] d);
      logic [191:0] w, m;
      m = 192'(64'hFFFF_FFFF_FFFF_FFFF) << (c * 64);
      w = (192'(r) & ~m) | (192'(d) << (c * 64));
      return w[OPW-1:0];
   endfunction

   function automatic logic [NOPS*OPW-1:0] rand_res();
      logic [NOPS*OPW-1:0] v;
      logic [191:0]        w;
      for (int k = 0; k < NOPS; k++) begin
         w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
         v[k*OPW +: OPW] = w[OPW-1:0];
      end
      return v;
   endfunction

   task automatic m_reset();
      for (int k = 0; k < NOPS; k++) m_reg[k] = '0;
      m_state = S_IDLE; m_err = 1'b0; m_tout = 1'b0;
      m_eidx = '0; m_echk = '0; m_eseq = 1'b0; m_rd = '0;
      exp_start = 1'b0; exp_abort = 1'b0;
   endtask

   task automatic m_quiet();
      exp_start = 1'b0;
      exp_abort = 1'b0;
   endtask

   // Command semantics: legality by (state, opcode), then the core handshake
   task automatic m_exec(input logic [7:0] op, input logic [7:0] idx, input logic [7:0] chk,
                         input logic sq, input logic [63:0] d, input logic done,
                         input logic [NOPS*OPW-1:0] res);
      logic       bad, was_run;
      logic [2:0] ri;
      bad     = (idx >= 8'(NOPS)) || (chk >= 8'(NCH));
      ri      = idx[2:0];
      was_run = (m_state == S_RUN);
      m_quiet();
      m_eidx = idx; m_echk = chk; m_eseq = sq;
      if (op == OP_NOP) begin
      end else if (op == OP_READ) begin
         if (bad) m_err = 1'b1;
         else     m_rd  = slice_of(m_reg[ri], int'(chk));
      end else if (op == OP_CLEAR && m_state != S_RUN) begin
         for (int k = 0; k < NOPS; k++) m_reg[k] = '0;
         m_err = 1'b0; m_tout = 1'b0; m_state = S_IDLE;
      end else if (op == OP_WRITE && (m_state == S_IDLE || m_state == S_DONE)) begin
         if (bad) m_err = 1'b1;
         else begin
            m_reg[ri] = put_slice(m_reg[ri], int'(chk), d);
            m_state   = S_IDLE;
         end
      end else if (op == OP_START && (m_state == S_IDLE || m_state == S_DONE)) begin
         m_state = S_RUN; exp_start = 1'b1;
      end else if (op == OP_ABORT && m_state == S_RUN) begin
         m_state = S_IDLE; exp_abort = 1'b1;
      end else begin
         m_err = 1'b1;
      end
      if (was_run && m_state == S_RUN && done) begin
         for (int k = 0; k < NOPS; k++) m_reg[k] = res[k*OPW +: OPW];
         m_state = S_DONE;
      end
   endtask

   task automatic check_all(input string tag);
      logic [127:0] w;
      w = {m_state, m_err, m_tout, 2'b00, m_eidx, m_echk, m_eseq, 39'd0, m_rd};
      check_eq({tag, ":status"}, 192'(la_data_out), 192'(w));
      for (int k = 0; k < NOPS; k++)
         check_eq($sformatf("%s:reg%0d", tag, k), 192'(core_op_o[k*OPW +: OPW]), 192'(m_reg[k]));
      check_eq({tag, ":start"}, 192'(core_start_o), 192'(exp_start));
      check_eq({tag, ":abort"}, 192'(core_abort_o), 192'(exp_abort));
   endtask

   // Present one sequence-tagged command; optional done pulse on its execute edge
   task automatic issue(input string tag, input logic [7:0] op, input logic [7:0] idx,
                        input logic [7:0] chk, input logic [63:0] d, input logic done,
                        input logic [NOPS*OPW-1:0] res);
      logic [127:0] junk;
      seq = ~seq;
      @(negedge clk);
      junk       = {$urandom(), $urandom(), $urandom(), $urandom()};
      la_data_in = {op, idx, chk, seq, junk[38:0], d};
      la_oenb    = {25'd0, junk[102:0]};
      @(posedge clk);
      @(negedge clk);
      core_done_i = done;
      core_res_i  = res;
      @(posedge clk);
      #1;
      core_done_i = 1'b0;
      m_exec(op, idx, chk, seq, d, done, res);
      check_all(tag);
   endtask

   initial begin
      logic [NOPS*OPW-1:0] res;
      int                  s0, a0, steps, run_cmds, r;
      logic [7:0]          op, idx, chk;
      logic                dn;

      rst_n = 1'b0; seq = 1'b0;
      la_data_in = '0; la_oenb = '1;
      core_done_i = 1'b0; core_res_i = '0;
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_word", 192'(la_data_out), 192'({4'h1, 124'd0}));
      check_all("reset");
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_all("post_reset");

      // Load, readback with truncated top slice, run and capture
      issue("wr0c0", OP_WRITE, 8'd0, 8'd0, 64'hDEAD_BEEF_0123_4567, 1'b0, '0);
      issue("wr0c2", OP_WRITE, 8'd0, 8'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, '0);
      issue("rd0c2", OP_READ, 8'd0, 8'd2, 64'd0, 1'b0, '0);
      check_eq("rd_c2", 192'(la_data_out[63:0]), 192'(64'h0000_0007_FFFF_FFFF));
      s0 = start_cnt;
      issue("start", OP_START, 8'd0, 8'd0, 64'd0, 1'b0, '0);
      repeat (3) @(posedge clk);
      #1;
      check_eq("start_pulses", 192'(start_cnt - s0), 192'(1));
      m_quiet();
      res = '0;
      res[OPW-1:0] = OPW'(5);
      issue("done", OP_NOP, 8'd0, 8'd0, 64'd0, 1'b1, res);
      check_eq("state_done", 192'(la_data_out[127:124]), 192'(4'h3));
      issue("rd_res", OP_READ, 8'd0, 8'd0, 64'd0, 1'b0, '0);
      check_eq("rd_res_val", 192'(la_data_out[63:0]), 192'(64'd5));

      // Held LA value executes once
      issue("hold_wr", OP_WRITE, 8'd1, 8'd1, 64'h1234_5678_9ABC_DEF0, 1'b0, '0);
      repeat (10) @(posedge clk);
      #1;
      check_eq("hold_echo", 192'(la_data_out[103]), 192'(seq));
      check_all("hold_wr_after");
      s0 = start_cnt;
      issue("hold_st", OP_START, 8'd0, 8'd0, 64'd0, 1'b0, '0);
      repeat (10) @(posedge clk);
      #1;
      m_quiet();
      check_all("hold_st_after");
      check_eq("hold_start_pulses", 192'(start_cnt - s0), 192'(1));
      issue("abort", OP_ABORT, 8'd0, 8'd0, 64'd0, 1'b0, '0);

      // Output-enable gating holds a toggled command back
      seq = ~seq;
      @(negedge clk);
      la_data_in = {OP_WRITE, 8'd2, 8'd0, seq, 39'd0, 64'hAAAA_5555_AAAA_5555};
      la_oenb    = 128'd1 << 110;
      repeat (4) @(posedge clk);
      #1;
      m_quiet();
      check_all("oenb_blocked");
      @(negedge clk) la_oenb = '0;
      repeat (2) @(posedge clk);
      #1;
      m_exec(OP_WRITE, 8'd2, 8'd0, seq, 64'hAAAA_5555_AAAA_5555, 1'b0, '0);
      check_all("oenb_released");

      // Bounds
      issue("bad_idx", OP_WRITE, 8'd7, 8'd0, 64'h1111, 1'b0, '0);
      check_eq("err_idx", 192'(la_data_out[123]), 192'(1));
      issue("bad_chk", OP_WRITE, 8'd0, 8'd3, 64'h2222, 1'b0, '0);
      issue("clear", OP_CLEAR, 8'd0, 8'd0, 64'd0, 1'b0, '0);
      check_eq("err_cleared", 192'(la_data_out[123]), 192'(0));

      // Watchdog
      issue("wd_wr", OP_WRITE, 8'd4, 8'd1, 64'hCAFE_F00D, 1'b0, '0);
      a0 = abort_cnt;
      issue("wd_start", OP_START, 8'd0, 8'd0, 64'd0, 1'b0, '0);
      steps = 0;
      for (int i = 1; i <= 64; i++) begin
         @(posedge clk);
         #1;
         steps = i;
         if (la_data_out[127:124] == S_TOUT) break;
      end
      check_eq("wd_cycles", 192'(steps), 192'(TMO));
      m_state = S_TOUT; m_tout = 1'b1; exp_start = 1'b0; exp_abort = 1'b1;
      check_all("wd_tout");
      repeat (2) @(posedge clk);
      #1;
      check_eq("wd_aborts", 192'(abort_cnt - a0), 192'(1));
      m_quiet();
      issue("tout_wr", OP_WRITE, 8'd0, 8'd0, 64'd9, 1'b0, '0);
      issue("tout_rd", OP_READ, 8'd4, 8'd1, 64'd0, 1'b0, '0);
      issue("tout_clr", OP_CLEAR, 8'd0, 8'd0, 64'd0, 1'b0, '0);

      // Abort racing done: abort wins, results dropped
      issue("race_wr", OP_WRITE, 8'd3, 8'd0, 64'h5A5A_5A5A_5A5A_5A5A, 1'b0, '0);
      issue("race_st", OP_START, 8'd0, 8'd0, 64'd0, 1'b0, '0);
      issue("race_ab", OP_ABORT, 8'd0, 8'd0, 64'd0, 1'b1, rand_res());

      // Randomized command stream
      run_cmds = 0;
      for (int it = 0; it < 250; it++) begin
         idx = ($urandom_range(0, 9) == 0) ? 8'd7 : 8'($urandom_range(0, 6));
         chk = ($urandom_range(0, 9) == 0) ? 8'd3 : 8'($urandom_range(0, 2));
         dn  = 1'b0;
         if (m_state == S_RUN && run_cmds >= 3) begin
            if ($urandom_range(0, 1) == 1) op = OP_ABORT;
            else begin op = OP_NOP; dn = 1'b1; end
         end else begin
            r = $urandom_range(0, 99);
            if      (r < 20) op = OP_WRITE;
            else if (r < 35) op = OP_START;
            else if (r < 55) op = OP_READ;
            else if (r < 62) op = OP_CLEAR;
            else if (r < 70) op = OP_ABORT;
            else if (r < 88) begin op = OP_NOP; dn = 1'($urandom_range(0, 1)); end
            else             op = 8'($urandom_range(6, 255));
         end
         if (m_state == S_RUN) run_cmds++;
         else                  run_cmds = 0;
         issue("rnd", op, idx, chk, {$urandom(), $urandom()}, dn, rand_res());
      end

      // Reset in RUN clears everything without an abort pulse
      issue("pre_ab", OP_ABORT, 8'd0, 8'd0, 64'd0, 1'b0, '0);
      issue("pre_clr", OP_CLEAR, 8'd0, 8'd0, 64'd0, 1'b0, '0);
      issue("pre_wr", OP_WRITE, 8'd6, 8'd2, 64'h7, 1'b0, '0);
      issue("pre_st", OP_START, 8'd0, 8'd0, 64'd0, 1'b0, '0);
      a0 = abort_cnt;
      @(negedge clk);
      la_data_in = '0; la_oenb = '1; rst_n = 1'b0; seq = 1'b0;
      #1;
      m_reset();
      check_all("mid_reset");
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_no_abort", 192'(abort_cnt - a0), 192'(0));
      check_all("after_mid_reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
